// File: rtl/muldiv_iterative_unit_if.sv
// rtl/muldiv_iterative_unit_if.sv - request/response bundle between the execute stage and the iterative mul/div unit
interface muldiv_iterative_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            err;

    modport master (
        output start, op, operand1, operand2, flush,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, operand1, operand2, flush,
        output busy, done, result, err
    );
endinterface

// File: rtl/muldiv_iterative_unit.sv
// rtl/muldiv_iterative_unit.sv - radix-2 iterative RV M-extension unit; divide datapath built only with MULDIV_DIV_EN
module muldiv_iterative_unit #(
    parameter int XLEN = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    muldiv_iterative_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                sign_q, sign_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                a_signed, b_signed;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step;
    logic [2*XLEN-1:0]   mul_full;
    logic [XLEN-1:0]     fix_result;
    logic                fix_err;

    // Operand magnitudes and signs for the request currently on the bus
    always_comb begin
        a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                   (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg    = a_signed & bus.operand1[XLEN-1];
        b_neg    = b_signed & bus.operand2[XLEN-1];
        a_mag    = a_neg ? -bus.operand1 : bus.operand1;
        b_mag    = b_neg ? -bus.operand2 : bus.operand2;
    end

    // Multiply: acc holds {partial high, remaining multiplier bits}, shifted right each cycle
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        mul_full = sign_q ? -acc_q : acc_q;
    end

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic                div_ovf;
    logic [XLEN:0]       div_partial;
    logic [XLEN:0]       div_diff;
    logic                div_qbit;
    logic [2*XLEN-1:0]   div_step;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;

    // Divide reuses acc as {remainder, dividend shifting out / quotient shifting in}
    always_comb begin
        div_ovf     = b_signed && (bus.operand1 == MIN_VAL) && (&bus.operand2);
        div_partial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff    = div_partial - {1'b0, opb_q};
        div_qbit    = ~div_diff[XLEN];
        div_step    = {(div_qbit ? div_diff[XLEN-1:0] : div_partial[XLEN-1:0]),
                       acc_q[XLEN-2:0], div_qbit};
        quot_fix    = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix     = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        fix_result = '0;
        fix_err    = 1'b0;
        case (op_q)
            OP_MUL:                       fix_result = mul_full[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = mul_full[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              fix_result = quot_fix;
            OP_REM, OP_REMU:              fix_result = rem_fix;
`endif
            default: begin
                fix_result = '0;
                fix_err    = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (bus.start) begin
                        op_d    = bus.op;
                        cnt_d   = '0;
                        state_d = S_CALC;
                        if (!bus.op[2]) begin
                            acc_d  = {{XLEN{1'b0}}, b_mag};
                            opb_d  = a_mag;
                            sign_d = a_neg ^ b_neg;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (bus.operand2 == '0) begin
                                acc_d   = {bus.operand1, {XLEN{1'b1}}};
                                sign_d  = 1'b0;
                                state_d = S_FIX;
                            end else if (div_ovf) begin
                                acc_d   = {{XLEN{1'b0}}, bus.operand1};
                                sign_d  = 1'b0;
                                state_d = S_FIX;
                            end else begin
                                acc_d  = {{XLEN{1'b0}}, a_mag};
                                opb_d  = b_mag;
                                sign_d = (bus.op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                            end
`else
                            state_d = S_FIX;
`endif
                        end
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
                    acc_d = op_q[2] ? div_step : mul_step;
`else
                    acc_d = mul_step;
`endif
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_result;
                    done_d   = 1'b1;
                    err_d    = fix_err;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// tb/tb_muldiv_iterative_unit.sv - directed self-checking bench for muldiv_iterative_unit (XLEN=32)
module tb_muldiv_iterative_unit;
    localparam int XLEN = 32;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    muldiv_iterative_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_iterative_unit #(.XLEN(XLEN)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Present a request, take the start edge (cycle 0), then scramble the inputs
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op       = op;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.start    = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start    = 1'b0;
        bus.op       = ~op;
        bus.operand1 = ~a;
        bus.operand2 = $urandom;
    endtask

    // Called in cycle 1; returns the cycle in which done rose and how many cycles busy was high
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 1;
        busy_n = 0;
        while (cyc < 100 && bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 3'd0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0};
        logic [31:0] as  [5] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};
        logic [31:0] exp [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd12};
        int cyc, bn;
        for (int i = 0; i < 5; i++) begin
            launch(ops[i], as[i], bs[i]);
            wait_done(cyc, bn);
            n_checks++; if (cyc != 34)            begin n_fail++; $display("FAIL mul_done_cycle[%0d]: got %0d expected 34", i, cyc); end
            n_checks++; if (bn != 33)             begin n_fail++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected 33", i, bn); end
            n_checks++; if (bus.result !== exp[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, bus.result, exp[i]); end
            n_checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_err_busy[%0d]: got err=%b busy=%b expected 0 0", i, bus.err, bus.busy); end
            @(posedge clk_i);
            #1;
            n_checks++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL mul_done_pulse[%0d]: got %b expected 0", i, bus.done); end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          ecyc[8] = '{34, 34, 34, 34, 2, 2, 2, 2};
        int cyc, bn;
        for (int i = 0; i < 8; i++) begin
            launch(ops[i], as[i], bs[i]);
            wait_done(cyc, bn);
            n_checks++; if (cyc != ecyc[i])       begin n_fail++; $display("FAIL div_done_cycle[%0d]: got %0d expected %0d", i, cyc, ecyc[i]); end
            n_checks++; if (bn != ecyc[i] - 1)    begin n_fail++; $display("FAIL div_busy_cycles[%0d]: got %0d expected %0d", i, bn, ecyc[i] - 1); end
            n_checks++; if (bus.result !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, bus.result, exp[i]); end
            n_checks++; if (bus.err !== 1'b0)     begin n_fail++; $display("FAIL div_err[%0d]: got %b expected 0", i, bus.err); end
            @(posedge clk_i);
            #1;
        end
    endtask
`else
    task automatic test_div_disabled();
        int cyc, bn;
        launch(3'd5, 32'd100, 32'd7);
        wait_done(cyc, bn);
        n_checks++; if (cyc != 2)              begin n_fail++; $display("FAIL nodiv_done_cycle: got %0d expected 2", cyc); end
        n_checks++; if (bus.result !== 32'd0)  begin n_fail++; $display("FAIL nodiv_result: got %h expected 0", bus.result); end
        n_checks++; if (bus.err !== 1'b1)      begin n_fail++; $display("FAIL nodiv_err: got %b expected 1", bus.err); end
        @(posedge clk_i);
        #1;
        n_checks++; if (bus.err !== 1'b0)      begin n_fail++; $display("FAIL nodiv_err_pulse: got %b expected 0", bus.err); end
        launch(3'd0, 32'd3, 32'd4);
        wait_done(cyc, bn);
        n_checks++; if (cyc != 34)             begin n_fail++; $display("FAIL nodiv_mul_cycle: got %0d expected 34", cyc); end
        n_checks++; if (bus.result !== 32'd12) begin n_fail++; $display("FAIL nodiv_mul_result: got %h expected 12", bus.result); end
        n_checks++; if (bus.err !== 1'b0)      begin n_fail++; $display("FAIL nodiv_mul_err: got %b expected 0", bus.err); end
        @(posedge clk_i);
        #1;
    endtask
`endif

    task automatic test_flush();
        int cyc, bn, seen;
        launch(3'd0, 32'd6, 32'd7);
        wait_done(cyc, bn);
        n_checks++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL flush_prior: got %h expected 42", bus.result); end
        @(posedge clk_i);
        #1;
        launch(3'd0, 32'd9, 32'd9);
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk_i);
        #1;
        bus.flush = 1'b0;
        n_checks++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL flush_result: got %h expected 42", bus.result); end
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = 3'd0;
        bus.operand1 = 32'd2;
        bus.operand2 = 32'd2;
        @(posedge clk_i);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        n_checks++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", bus.busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen++;
            @(posedge clk_i);
            #1;
        end
        n_checks++; if (seen != 0)             begin n_fail++; $display("FAIL flush_no_done: got %0d done pulses expected 0", seen); end
        n_checks++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL flush_result_held: got %h expected 42", bus.result); end
    endtask

    task automatic test_back_to_back();
        int cyc, bn;
        launch(3'd0, 32'd5, 32'd6);
        wait_done(cyc, bn);
        n_checks++; if (bus.result !== 32'd30) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 30", bus.result); end
        launch(3'd0, 32'd11, 32'd13);
        wait_done(cyc, bn);
        n_checks++; if (cyc != 34)              begin n_fail++; $display("FAIL b2b_second_cycle: got %0d expected 34", cyc); end
        n_checks++; if (bus.result !== 32'd143) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 143", bus.result); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_mid_reset();
        launch(3'd0, 32'd2, 32'd3);
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", bus.result); end
        n_checks++; if (bus.err !== 1'b0)     begin n_fail++; $display("FAIL midrst_err: got %b expected 0", bus.err); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mul();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_flush();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_iterative_unit.md
# muldiv_iterative_unit

Parametrised iterative M-extension execute unit covering all eight RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind one start/done handshake. It sits beside the ALU in the Execute stage. The hazard unit holds Fetch/Decode and freezes the E-stage register while `busy` is high. It is the successor to the fixed 32-bit multiply-only iterative multiplier: XLEN is generic, it adds signed/unsigned division and remainder, and it adds pipeline flush support.

## Interface
Parameters:
- XLEN, 32, operand/result width; any even value ≥ 8.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only when `busy`=0.
- op, input, 3, funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand1, input, XLEN, rs1 (multiplicand/dividend).
- operand2, input, XLEN, rs2 (multiplier/divisor).
- flush, input, 1, abort the current operation (branch taken in E).
- busy, output, 1, operation in progress; new `start` is ignored.
- done, output, 1, one-cycle pulse; `result` is valid in the same cycle.
- result, output, XLEN, result register; holds its value until the next accepted `start`.
- err, output, 1, pulses with `done` when an unsupported op completes (see Configuration).

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE + start: latch op, take operand magnitudes (signedness from op; MULHSU has rs1 signed and rs2 unsigned), record result sign, clear the iteration counter, busy←1.
  - Next state is CALC.
  - Exception: a division special case goes straight to FIX.
- CALC: radix-2, one bit per cycle, XLEN iterations.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract producing a quotient and remainder.
  - The counter is $clog2(XLEN)+1 bits wide. After iteration XLEN-1 the FSM moves to FIX.
- FIX: apply two's-complement negation where needed.
  - Product: negated if the operand signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the dividend's sign.
  - Select the output: MUL takes the low XLEN bits, MULH* the high XLEN bits.
  - Write `result`; next state is DONE.
- DONE: done=1, busy=0. Next state is IDLE. A `start` in this cycle is accepted, giving back-to-back operation.
- Division special cases, resolved without CALC:
  - Divisor 0: quotient all-ones; remainder = operand1.
  - Signed overflow (operand1 = −2^(XLEN−1), operand2 = −1): quotient = operand1; remainder = 0.
- flush: in any state, the FSM returns to IDLE on the next edge. busy←0, no `done`, `result` unchanged.
  - flush and start in the same cycle: flush wins; the start is dropped.
- Reset: state IDLE. busy, done, err and result all 0. Counter and accumulators are cleared. Mid-operation reset discards the operation with no `done`.

## Timing
- The start edge is cycle 0.
- Normal op: `done` is high in cycle XLEN+2 (34 for XLEN=32). busy is high in cycles 1..XLEN+1.
- Division special case: `done` is high in cycle 2; busy is high in cycle 1 only.
- `done` is registered and never high for two consecutive cycles unless a back-to-back start was accepted in the DONE cycle.
- Operands are captured at the start edge; later changes on operand1/operand2/op have no effect.
- `result` changes only at the FIX→DONE edge.

## Configuration
- MULDIV_DIV_EN defined: the divide datapath is built and op 4–7 execute as described.
- MULDIV_DIV_EN undefined: the divide datapath and its registers are removed.
  - op 4–7 go IDLE→FIX→DONE with result=0, done and err high in cycle 2.
  - Multiply behaviour is unchanged.
- err is always 0 when the macro is defined.

## Test plan
All scenarios use XLEN=32 with MULDIV_DIV_EN defined unless stated.
- MUL 0x0000_0007 × 0xFFFF_FFFD (−3) → result 0xFFFF_FFEB, done in cycle 34, busy high for cycles 1–33.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV −7 / 2 → 0xFFFF_FFFD. REM −7 / 2 → 0xFFFF_FFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFF_FFFF and REM 5 / 0 → 5, each with done in cycle 2. DIV 0x8000_0000 / −1 → 0x8000_0000 and REM → 0.
- Flush asserted in cycle 10 of a MUL → IDLE, no done, result keeps the prior value. A start in the DONE cycle yields a second done exactly 34 cycles later. rst low in cycle 5 → all outputs 0 immediately.
- MULDIV_DIV_EN undefined: DIVU 100 / 7 → result 0, err=1 with done in cycle 2. A following MUL 3 × 4 → 12 with err=0.
